// File: rtl/axi_line_sched_pkg.sv
// Shared types, default geometry and burst clipping for the AXI line read scheduler.
package axi_line_sched_pkg;

  localparam int unsigned BYTES_PER_BEAT = 16;
  localparam int unsigned LINE_BEATS     = 480;
  localparam int unsigned RemW           = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StIssue,
    StWait
  } state_e;

  // Beats for the next burst: bounded by what is left of the line, the burst cap and the
  // distance to the next 4 KB boundary. Addresses are beat aligned, so the room is never 0.
  function automatic logic [8:0] clip_beats(input logic [11:0]     addr,
                                            input logic [RemW-1:0] remaining,
                                            input logic [8:0]      max_beats,
                                            input int unsigned     beat_shift);
    logic [12:0]     room;
    logic [RemW-1:0] beats;
    room  = (13'h1000 - {1'b0, addr}) >> beat_shift;
    beats = remaining;
    if (RemW'(room) < beats) beats = RemW'(room);
    if (RemW'(max_beats) < beats) beats = RemW'(max_beats);
    return beats[8:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr) + i) % NUM_REQ;
      if (!valid && req[IdxW'(j)]) begin
        valid            = 1'b1;
        grant[IdxW'(j)]  = 1'b1;
        idx              = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_line_read_scheduler.sv
// Grants one requester per video line and splits the line into AXI read bursts that
// never exceed MAX_BURST beats nor cross a 4 KB boundary.
module axi_line_read_scheduler
  import axi_line_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned AXI4_DATA_WIDTH = BYTES_PER_BEAT * 8,
  parameter int unsigned H_DISP          = 1920,
  parameter int unsigned MAX_BURST       = 128
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_FRAME_START,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_BASE_ADDR,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic                          M_CMD_VALID,
  output logic [ADDR_WIDTH-1:0]         M_CMD_ADDR,
  output logic [7:0]                    M_CMD_LEN,
  output logic [$clog2(NUM_REQ)-1:0]    M_CMD_ID,
  input  logic                          M_CMD_READY,
  input  logic                          M_CMD_DONE,
  output logic                          BUSY
);

  localparam int unsigned IdxW      = $clog2(NUM_REQ);
  localparam int unsigned BeatBytes = AXI4_DATA_WIDTH / 8;
  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned LineBeats = H_DISP * 4 / BeatBytes;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, gnt_q;
  logic [NUM_REQ-1:0]    ready_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [RemW-1:0]       remaining_q;
  logic [8:0]            beats_q, calc_beats;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] line_ptr_q [NUM_REQ];
  logic [ADDR_WIDTH-1:0] base_arr   [NUM_REQ];

  logic [NUM_REQ-1:0] arb_grant;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_base
    assign base_arr[gi] = REQ_BASE_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req  (REQ_VALID),
    .ptr  (rr_ptr_q),
    .grant(arb_grant),
    .idx  (arb_idx),
    .valid(arb_valid)
  );

  assign calc_beats = clip_beats(cur_addr_q[11:0], remaining_q, 9'(MAX_BURST), BeatShift);

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state_q <= StIdle;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (arb_valid) state_d = StCalc;
      StCalc:  state_d = StIssue;
      StIssue: if (M_CMD_READY) state_d = StWait;
      StWait:  if (M_CMD_DONE) state_d = (remaining_q != '0) ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      ready_q     <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      len_q       <= '0;
      for (int i = 0; i < NUM_REQ; i++) line_ptr_q[i] <= '0;
    end else begin
      ready_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            ready_q     <= arb_grant;
            gnt_q       <= arb_idx;
            cur_addr_q  <= REQ_FRAME_START[arb_idx] ? base_arr[arb_idx] : line_ptr_q[arb_idx];
            remaining_q <= RemW'(LineBeats);
          end
        end
        StCalc: begin
          beats_q <= calc_beats;
          len_q   <= 8'(calc_beats - 9'd1);
        end
        StIssue: begin
          if (M_CMD_READY) begin
            cur_addr_q  <= cur_addr_q + (ADDR_WIDTH'(beats_q) << BeatShift);
            remaining_q <= remaining_q - RemW'(beats_q);
          end
        end
        StWait: begin
          // Line finished: remember where the next line starts and rotate priority.
          if (M_CMD_DONE && remaining_q == '0) begin
            line_ptr_q[gnt_q] <= cur_addr_q;
            rr_ptr_q <= (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign REQ_READY   = ready_q;
  assign M_CMD_VALID = (state_q == StIssue);
  assign M_CMD_ADDR  = cur_addr_q;
  assign M_CMD_LEN   = len_q;
  assign M_CMD_ID    = gnt_q;
  assign BUSY        = (state_q != StIdle);

endmodule
